fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch stage with a prefetch buffer. It issues word fetches to a synchronous instruction memory and buffers the returned 16-bit words with their PCs in a small queue. Decode sees a two-word window and can take 0, 1 or 2 words per cycle, which covers 16-bit and 32-bit instructions. It sits between instruction memory and decode, and handles absolute and relative redirects plus a pipeline stop.

Parameters:
ADDR_W, 20, word-address width of PC and memory address
WORD_W, 16, instruction memory word width
OFF_W, 9, signed relative-branch offset width (in words)
QDEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 0, fetch PC after reset

Ports:
clock  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
stop  in  1  pipeline freeze: no issue, no take
imem_req  out  1  fetch request this cycle
imem_addr  out  ADDR_W  word address of request
imem_rdata  in  WORD_W  read data, valid exactly 1 cycle after imem_req
redir_valid  in  1  redirect request
redir_rel  in  1  0 = absolute, 1 = relative
redir_target  in  ADDR_W  absolute target
redir_base  in  ADDR_W  base PC for relative redirect
redir_off  in  OFF_W  signed word offset for relative redirect
out_cnt  out  2  words available in window (0, 1 or 2)
out_insn  out  2*WORD_W  [2W-1:W] = head word, [W-1:0] = head+1 word
out_pc  out  ADDR_W  PC of head word
out_take  in  2  words consumed this cycle

Behaviour:
- Reset (synchronous, active-high, clock clock): fetch_pc=RESET_PC; queue empty; inflight=0; imem_req=0; out_cnt=0; out_insn=0; out_pc=0. Reset overrides every other input.
- State: fetch_pc; inflight flag (1 bit, fixed 1-cycle memory latency); queue of (pc, word) entries with count 0..QDEPTH.
- Issue (combinational from registered state):
  - imem_req=1 iff !stop && !redir_valid && (count+inflight) < QDEPTH; imem_addr=fetch_pc.
  - The slot check ignores same-cycle out_take, which is conservative.
  - On issue, fetch_pc <= fetch_pc+1 (mod 2^ADDR_W, wraps silently) and inflight <= 1; otherwise inflight <= 0.
- Response: when inflight=1, imem_rdata is pushed with PC fetch_pc-1 at the edge, unless redir_valid or reset in that cycle. stop does not drop the response; its slot was already reserved.
- Output:
  - out_cnt = min(count, 2).
  - Words not present read as 0.
  - out_pc = head PC, or 0 when empty.
- Take:
  - out_take is honoured only if !stop && !redir_valid.
  - take > out_cnt is a protocol error: the bench asserts, RTL clamps to out_cnt.
  - Push and pop in the same cycle are legal; the queue never overflows by construction.
- Redirect:
  - Target = redir_rel ? redir_base + sext(redir_off) : redir_target, mod 2^ADDR_W.
  - At the edge: fetch_pc <= target, queue cleared, inflight <= 0, in-flight response discarded.
  - Redirect has priority over stop and take.
  - First request goes out the cycle after the redirect edge; out_cnt>=1 two edges after the redirect edge.
- stop held: all state frozen except the response push; imem_req=0.

Optional Feature:
BYTE_SWAP_EN:
- Defined: each incoming word is byte-swapped before it is queued, so {b1,b0} is stored as {b0,b1} (little-endian memory image). WORD_W must be a multiple of 16.
- Undefined: the word is stored as received.

Decomposition:
- Shared package fetch_pkg: redirect mode constants (REDIR_ABS=0, REDIR_REL=1), the queue entry struct typedef (pc, word), and the take-count encoding.
- Natural sub-module fetch_queue: a QDEPTH circular buffer with single push, 0/1/2 pop, synchronous clear, and a two-entry head window output.

Test Plan:
- Reset then run with stop=0 and out_take=0 -> requests at addresses 0,1,2,3, then imem_req=0 (queue full); out_cnt=2, out_pc=0.
- Steady state with out_take=1 every cycle and memory word[i]=i -> out_pc steps 0,1,2,... each cycle with no bubbles after fill; out_insn={i,i+1}.
- Relative redirect with base=0x10, off=-3 (9'h1FD) while 3 words are queued -> queue flushed, next imem_addr=0x0D, out_pc=0x0D two edges later.
- Absolute redirect to 0xFFFFF, run 3 fetches -> addresses 0xFFFFF, 0x00000, 0x00001 (wrap-around).
- Redirect in the same cycle as an inflight response and out_take=2 -> response dropped, no words popped, queue empty after the edge.
- stop asserted with 1 request in flight -> the word is still queued; no new request while stopped; resume restarts at the next PC. With BYTE_SWAP_EN defined, word 0x1234 is presented as 0x3412.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: redirect modes, queue entry, take encoding.
package fetch_pkg;

  localparam logic REDIR_ABS = 1'b0;
  localparam logic REDIR_REL = 1'b1;

  localparam int FQ_ADDR_W = 20;
  localparam int FQ_WORD_W = 16;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_WORD_W-1:0] word;
  } fq_entry_t;

  typedef enum logic [1:0] {
    TAKE_NONE = 2'd0,
    TAKE_ONE  = 2'd1,
    TAKE_TWO  = 2'd2
  } take_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch buffer: single push, 0/1/2 pop, sync clear,
// two-entry head window (absent entries read as zero).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int WORD_W = 16,
  parameter int QDEPTH = 4,
  parameter int CW     = $clog2(QDEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [WORD_W-1:0] push_word,
  input  take_e             pop,
  output logic [CW-1:0]     count,
  output logic [ADDR_W-1:0] head_pc,
  output logic [WORD_W-1:0] head_word,
  output logic [WORD_W-1:0] next_word
);

  localparam int PW = $clog2(QDEPTH);

  logic [ADDR_W-1:0] pc_mem   [QDEPTH];
  logic [WORD_W-1:0] word_mem [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     nx_ptr;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= push_pc;
        word_mem[wr_ptr] <= push_word;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  assign nx_ptr    = rd_ptr + PW'(1);
  assign head_pc   = (count != '0) ? pc_mem[rd_ptr] : '0;
  assign head_word = (count != '0) ? word_mem[rd_ptr] : '0;
  assign next_word = (count >= CW'(2)) ? word_mem[nx_ptr] : '0;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage with prefetch queue and two-word decode window.
// Optional BYTE_SWAP_EN swaps bytes of each 16-bit lane before queueing.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 20,
  parameter int                 WORD_W   = 16,
  parameter int                 OFF_W    = 9,
  parameter int                 QDEPTH   = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stop,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [WORD_W-1:0]   imem_rdata,
  input  logic                redir_valid,
  input  logic                redir_rel,
  input  logic [ADDR_W-1:0]   redir_target,
  input  logic [ADDR_W-1:0]   redir_base,
  input  logic [OFF_W-1:0]    redir_off,
  output logic [1:0]          out_cnt,
  output logic [2*WORD_W-1:0] out_insn,
  output logic [ADDR_W-1:0]   out_pc,
  input  logic [1:0]          out_take
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic [ADDR_W-1:0] target;
  logic [WORD_W-1:0] word_in;
  logic [WORD_W-1:0] head_word;
  logic [WORD_W-1:0] next_word;
  logic              push;
  logic              take_ok;
  take_e             take_eff;

  // Slot check counts the reserved in-flight slot, ignores same-cycle take.
  assign occ      = {1'b0, count} + (CW+1)'(inflight);
  assign imem_req = !reset && !stop && !redir_valid
                    && (occ < (CW+1)'(QDEPTH));
  assign imem_addr = fetch_pc;

  assign target = (redir_rel == REDIR_REL)
    ? redir_base + {{(ADDR_W-OFF_W){redir_off[OFF_W-1]}}, redir_off}
    : redir_target;

  assign out_cnt  = (count >= CW'(2)) ? 2'd2 : count[1:0];
  assign take_ok  = !stop && !redir_valid;
  assign take_eff = !take_ok ? TAKE_NONE
                  : (out_take > out_cnt) ? take_e'(out_cnt)
                  : take_e'(out_take);
  assign push     = inflight && !redir_valid;

`ifdef BYTE_SWAP_EN
  always_comb begin
    word_in = '0;
    for (int i = 0; i < WORD_W / 16; i++) begin
      word_in[16*i +: 8]   = imem_rdata[16*i+8 +: 8];
      word_in[16*i+8 +: 8] = imem_rdata[16*i +: 8];
    end
  end
`else
  assign word_in = imem_rdata;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (redir_valid) begin
      fetch_pc <= target;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req)
        fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .QDEPTH (QDEPTH),
    .CW     (CW)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (redir_valid),
    .push      (push),
    .push_pc   (fetch_pc - ADDR_W'(1)),
    .push_word (word_in),
    .pop       (take_eff),
    .count     (count),
    .head_pc   (out_pc),
    .head_word (head_word),
    .next_word (next_word)
  );

  assign out_insn = {head_word, next_word};

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed and random checks of fetch_queue_unit against a queue-based model.
module tb_fetch_queue_unit;

  localparam int AW = 20;
  localparam int WW = 16;
  localparam int OW = 9;
  localparam int QD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          stop;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [WW-1:0] imem_rdata;
  logic          redir_valid;
  logic          redir_rel;
  logic [AW-1:0] redir_target;
  logic [AW-1:0] redir_base;
  logic [OW-1:0] redir_off;
  logic [1:0]    out_cnt;
  logic [2*WW-1:0] out_insn;
  logic [AW-1:0] out_pc;
  logic [1:0]    out_take;

  fetch_queue_unit dut (
    .clock        (clock),
    .reset        (reset),
    .stop         (stop),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .redir_valid  (redir_valid),
    .redir_rel    (redir_rel),
    .redir_target (redir_target),
    .redir_base   (redir_base),
    .redir_off    (redir_off),
    .out_cnt      (out_cnt),
    .out_insn     (out_insn),
    .out_pc       (out_pc),
    .out_take     (out_take)
  );

  always #5 clock = ~clock;

  logic [WW-1:0] salt = '0;

  function automatic logic [WW-1:0] memf(input logic [AW-1:0] a);
    return a[WW-1:0] ^ salt;
  endfunction

  function automatic logic [WW-1:0] stored(input logic [WW-1:0] w);
`ifdef BYTE_SWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  always @(posedge clock) begin
    if (imem_req) imem_rdata <= memf(imem_addr);
  end

  typedef struct {
    logic [AW-1:0] pc;
    logic [WW-1:0] w;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  bit            m_infl;
  logic [WW-1:0] m_pend;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_avail();
    return (mq.size() >= 2) ? 2 : mq.size();
  endfunction

  // One cycle: drive, check at negedge against model, advance model at edge.
  task automatic step(input bit st, input int tk, input bit rv,
                      input bit rr, input logic [AW-1:0] rt,
                      input logic [AW-1:0] rb, input logic [OW-1:0] ro);
    bit            exp_req;
    logic [WW-1:0] h0;
    logic [WW-1:0] h1;
    logic [AW-1:0] hp;
    logic [AW-1:0] tgt;
    stop = st; out_take = 2'(tk); redir_valid = rv;
    redir_rel = rr; redir_target = rt; redir_base = rb; redir_off = ro;
    @(negedge clock);
    exp_req = !st && !rv && (mq.size() + int'(m_infl) < QD);
    h0 = (mq.size() >= 1) ? mq[0].w : '0;
    h1 = (mq.size() >= 2) ? mq[1].w : '0;
    hp = (mq.size() >= 1) ? mq[0].pc : '0;
    check("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("out_cnt", 64'(out_cnt), 64'(m_avail()));
    check("out_insn", 64'(out_insn), 64'({h0, h1}));
    check("out_pc", 64'(out_pc), 64'(hp));
    if (rv) begin
      tgt = rr ? rb + AW'($signed(ro)) : rt;
      m_pc = tgt; mq.delete(); m_infl = 0;
    end else begin
      if (!st) for (int i = 0; i < tk; i++) void'(mq.pop_front());
      if (m_infl) mq.push_back('{m_pc - AW'(1), stored(m_pend)});
      if (exp_req) begin
        m_pend = memf(m_pc); m_pc = m_pc + AW'(1); m_infl = 1;
      end else m_infl = 0;
    end
    @(posedge clock); #1;
  endtask

  task automatic run(input bit st, input int tk, input int n);
    for (int i = 0; i < n; i++) step(st, tk, 0, 0, '0, '0, '0);
  endtask

  initial begin
    reset = 1; stop = 0; out_take = 0; redir_valid = 0; redir_rel = 0;
    redir_target = '0; redir_base = '0; redir_off = '0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    mq.delete(); m_pc = '0; m_infl = 0; m_pend = '0;

    // reset state before any edge
    check("rst_cnt", 64'(out_cnt), 64'd0);
    check("rst_insn", 64'(out_insn), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);

    // fill with no take: four requests then full
    run(0, 0, 7);
    check("full_cnt", 64'(out_cnt), 64'd2);
    check("full_req", 64'(imem_req), 64'd0);
    check("full_insn", 64'(out_insn), 64'h0000_0001);

    // steady take of one word per cycle
    run(0, 1, 12);
    check("steady_cnt", 64'(out_cnt), 64'd2);

    // relative redirect base 0x10 off -3
    step(0, 0, 1, 1, '0, 20'h10, 9'h1FD);
    check("rel_addr", 64'(imem_addr), 64'h0D);
    run(0, 0, 2);
    check("rel_pc", 64'(out_pc), 64'h0D);

    // absolute redirect with wrap-around
    step(0, 1, 1, 0, 20'hFFFFF, '0, '0);
    check("abs_addr0", 64'(imem_addr), 64'hFFFFF);
    run(0, 0, 1);
    check("abs_addr1", 64'(imem_addr), 64'h00000);
    run(0, 0, 1);
    check("abs_addr2", 64'(imem_addr), 64'h00001);
    run(0, 0, 3);

    // redirect while a response is in flight, take=2 ignored
    run(0, 2, 1);
    step(0, 2, 1, 0, 20'h00300, '0, '0);
    check("flush_cnt", 64'(out_cnt), 64'd0);

    // stop with one request in flight
    run(0, 0, 1);
    run(1, 1, 3);
    check("stop_cnt", 64'(out_cnt), 64'd1);
    check("stop_pc", 64'(out_pc), 64'h300);
    run(0, 0, 1);
    check("resume_addr", 64'(imem_addr), 64'h302);

    // byte-lane check on a known word
    step(0, 0, 1, 0, 20'h01234, '0, '0);
    run(0, 0, 2);
`ifdef BYTE_SWAP_EN
    check("swap_word", 64'(out_insn[31:16]), 64'h3412);
`else
    check("swap_word", 64'(out_insn[31:16]), 64'h1234);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit st;
      bit rv;
      if (i == 200) salt = 16'h5A3C;
      st = ($urandom_range(7) == 0);
      rv = ($urandom_range(15) == 0);
      step(st, $urandom_range(m_avail()), rv, 1'($urandom),
           AW'($urandom), AW'($urandom), OW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
